// File: rtl/aes_pkg.sv
// aes_pkg: shared key-schedule FSM state type, round count default and key/word widths.
package aes_pkg;
    localparam int KEY_W          = 128;
    localparam int WORD_W         = 32;
    localparam int NUM_ROUNDS_DEF = 10;
    typedef enum logic [1:0] {IDLE, EMIT, STEP} ks_state_t;
endpackage

// File: rtl/g_function.sv
// g_function: AES key-schedule g() = SubWord(RotWord(w)) ^ {Rcon(rc_idx), 24'h0}.
module g_function
    import aes_pkg::*;
(
    input  logic [WORD_W-1:0] w,
    input  logic [3:0]        rc_idx,
    output logic [WORD_W-1:0] g
);
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // S-box built from its definition: inverse as a^254, then the affine map
    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 7; i >= 0; i--) begin
            r = gmul(r, r);
            if (i != 0) r = gmul(r, a);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] n);
        logic [7:0] r;
        r = 8'h01;
        for (int i = 1; i < 16; i++) if (i < int'(n)) r = gmul(r, 8'h02);
        return r;
    endfunction

    assign g = {sbox(w[23:16]) ^ rcon(rc_idx), sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
endmodule

// File: rtl/key_expansion_ctrl.sv
// key_expansion_ctrl: AES-128 round-key generator streaming one key per valid/ready handshake.
// Define ROUND_KEY_STORE_EN to add a round-key register file with a combinational read port.
module key_expansion_ctrl
    import aes_pkg::*;
#(
    parameter int NUM_ROUNDS = NUM_ROUNDS_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [KEY_W-1:0] key_in,
    input  logic             rk_ready,
`ifdef ROUND_KEY_STORE_EN
    input  logic [3:0]       rd_round,
    output logic [KEY_W-1:0] rd_key,
`endif
    output logic             busy,
    output logic             rk_valid,
    output logic [3:0]       rk_round,
    output logic [KEY_W-1:0] rk_data,
    output logic             done
);
    localparam logic [3:0] LAST = 4'(NUM_ROUNDS);

    ks_state_t         state, state_nx;
    logic [KEY_W-1:0]  key, key_nx;
    logic [3:0]        round, round_nx;
    logic [WORD_W-1:0] g, w4, w5, w6, w7;
    logic              hs, load, step;

    assign hs   = state == EMIT && rk_ready;
    assign load = state == IDLE && start;
    assign step = state == STEP;

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_nx;

    always_comb
        state_nx = state == IDLE ? (start ? EMIT : IDLE)
                 : state == STEP ? EMIT
                 : hs ? (round == LAST ? IDLE : STEP) : EMIT;

    always_comb begin
        busy     = state != IDLE;
        rk_valid = state == EMIT;
    end

    // rcon index is pinned to 1 outside STEP so it never leaves 1..NUM_ROUNDS
    g_function u_g (.w(key[31:0]), .rc_idx(step ? round + 4'd1 : 4'd1), .g(g));

    assign w4       = key[127:96] ^ g;
    assign w5       = w4 ^ key[95:64];
    assign w6       = w5 ^ key[63:32];
    assign w7       = w6 ^ key[31:0];
    assign key_nx   = load ? key_in : {w4, w5, w6, w7};
    assign round_nx = load ? 4'd0 : round + 4'd1;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            key   <= '0;
            round <= '0;
            done  <= 1'b0;
        end else begin
            done <= hs && round == LAST;
            if (load || step) begin
                key   <= key_nx;
                round <= round_nx;
            end
        end

    assign rk_round = round;
    assign rk_data  = key;

`ifdef ROUND_KEY_STORE_EN
    logic [KEY_W-1:0] store [NUM_ROUNDS+1];

    always_ff @(posedge clk or posedge rst)
        if (rst) for (int i = 0; i <= NUM_ROUNDS; i++) store[i] <= '0;
        else if (load || step) store[round_nx] <= key_nx;

    assign rd_key = rd_round <= LAST ? store[rd_round] : '0;
`endif
endmodule

// File: tb/tb_key_expansion_ctrl.sv
// tb_key_expansion_ctrl: scoreboard bench for the streaming AES-128 key expansion controller.
module tb_key_expansion_ctrl;
    logic         clk = 0, rst = 1, start = 0, rk_ready = 0;
    logic [127:0] key_in = '0;
    logic         busy, rk_valid, done;
    logic [3:0]   rk_round;
    logic [127:0] rk_data;
`ifdef ROUND_KEY_STORE_EN
    logic [3:0]   rd_round = '0;
    logic [127:0] rd_key;
`endif
    int checks = 0, failures = 0;
    logic [131:0] sb [$];

    localparam logic [127:0] KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] JUNK = 128'hffffffff00000000deadbeefcafef00d;
    logic [127:0] exp_keys [0:10] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6};

    always #5 clk = ~clk;

    key_expansion_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .key_in(key_in), .rk_ready(rk_ready),
`ifdef ROUND_KEY_STORE_EN
        .rd_round(rd_round), .rd_key(rd_key),
`endif
        .busy(busy), .rk_valid(rk_valid), .rk_round(rk_round), .rk_data(rk_data), .done(done));

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // monitor: every accepted round key must match the head of the scoreboard
    always @(negedge clk)
        if (!rst && rk_valid && rk_ready) begin
            if (sb.size() == 0) chk("sb_unexpected_key", {124'd0, rk_round}, 128'hx);
            else begin
                logic [131:0] e;
                e = sb.pop_front();
                chk("sb_round", {124'd0, rk_round}, {124'd0, e[131:128]});
                chk("sb_data", rk_data, e[127:0]);
            end
        end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_all();
        for (int r = 0; r <= 10; r++) sb.push_back({4'(r), exp_keys[r]});
    endtask

    task automatic do_start(input logic [127:0] k);
        start = 1;
        key_in = k;
        tick();
        start = 0;
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        while (!done && n < 80) begin
            tick();
            n++;
        end
        chk(nm, {127'd0, done}, 128'd1);
    endtask

    task automatic wait_round(input logic [3:0] r);
        int n = 0;
        while (!(rk_valid && rk_round == r) && n < 80) begin
            tick();
            n++;
        end
        chk("reach_round", {124'd0, rk_round, 3'd0, rk_valid}, {124'd0, r, 4'd1});
    endtask

    initial begin
        int dl;
        tick();
        tick();
        chk("reset_ctrl", {124'd0, busy, rk_valid, done, |rk_round}, 128'd0);
        chk("reset_data", rk_data, 128'd0);
        rst = 0;
        rk_ready = 1;
        tick(); tick(); tick();
        chk("idle_after_reset", {126'd0, rk_valid, busy}, 128'd0);

        // no-stall run with latency checks
        push_all();
        do_start(KEY);
        chk("r0_at_t1", {124'd0, rk_round, 3'd0, rk_valid}, {124'd0, 4'd0, 4'd1});
        dl = 0;
        for (int i = 2; i <= 40; i++) begin
            tick();
            if (i == 3)  chk("r1_at_t3", {124'd0, rk_round, 3'd0, rk_valid}, {124'd0, 4'd1, 4'd1});
            if (i == 21) chk("r10_at_t21", {124'd0, rk_round, 3'd0, rk_valid}, {124'd0, 4'd10, 4'd1});
            if (done) begin
                dl = i;
                break;
            end
        end
        chk("done_latency", 128'(dl), 128'd22);
        chk("done_cycle_idle", {127'd0, busy}, 128'd0);

        // start in the done cycle, then a glitching start while busy
        push_all();
        do_start(KEY);
        chk("restart_r0", {124'd0, rk_round, 2'd0, done, rk_valid}, {124'd0, 4'd0, 4'd1});
        tick(); tick();
        do_start(JUNK);
        wait_done("done_after_glitch");

        // stall five cycles at round 3
        tick();
        push_all();
        do_start(KEY);
        wait_round(4'd3);
        rk_ready = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_ctrl", {124'd0, rk_round, 2'd0, busy, rk_valid}, {124'd0, 4'd3, 4'd3});
            chk("stall_data", rk_data, exp_keys[3]);
        end
        rk_ready = 1;
        wait_done("done_after_stall");

        // reset during STEP of round 6
        tick();
        push_all();
        do_start(KEY);
        wait_round(4'd6);
        tick();
        chk("in_step6", {124'd0, rk_round, 2'd0, busy, rk_valid}, {124'd0, 4'd6, 4'd2});
        rst = 1;
        #1;
        sb.delete();
        chk("async_rst_ctrl", {124'd0, busy, rk_valid, done, |rk_round}, 128'd0);
        chk("async_rst_data", rk_data, 128'd0);
        tick();
        rst = 0;
        tick(); tick();
        chk("no_emit_after_rst", {126'd0, rk_valid, busy}, 128'd0);
        push_all();
        do_start(KEY);
        wait_done("done_after_rst");
        tick();
        chk("sb_drained", 128'(sb.size()), 128'd0);

`ifdef ROUND_KEY_STORE_EN
        rd_round = 4'd1;
        #1 chk("store_r1", rd_key, exp_keys[1]);
        rd_round = 4'd10;
        #1 chk("store_r10", rd_key, exp_keys[10]);
        rd_round = 4'd15;
        #1 chk("store_oob", rd_key, 128'd0);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
